port_serial_tx: RTL and testbench
=================================

# port_serial_tx

Serial transmitter peripheral for the single-cycle CPU's output ports. It takes bytes the CPU writes to an output port register, buffers them in a 4-entry FIFO, and shifts each one out on a single line as an asynchronous frame: one start bit, 8 data bits LSB first, one stop bit. A status byte goes back to the CPU through an input port. A level interrupt request goes to the interrupt manager when the transmitter has drained completely.

## Interface
- DIV, 4: clock cycles per serial bit; legal range 2..65535.
- DEPTH, 4: FIFO entries; fixed at 4, not to be overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  write strobe, driven by the CPU's output-port write enable (owe); one byte is offered per cycle it is high.
- din  in  8  byte to transmit, driven by the output-port register contents.
- ack_int  in  1  interrupt acknowledge (end-of-interrupt from the CPU); clears int_req and ovf.
- tx  out  1  serial line; registered; idles high.
- status  out  8  {1'b0, count[2:0], ovf, int_req, full, busy}, for an input port.
- int_req  out  1  level interrupt request to the interrupt manager.

## Operation
- FIFO
  - Write accepted when wr=1 and count<4.
  - When wr=1 and count=4 in a cycle with no pop, the byte is dropped and ovf is set (sticky).
  - In a cycle with both a pop and a write while full, the write is accepted; count stays 4 and ovf is unchanged.
  - Storage is a circular buffer with 2-bit read/write pointers that wrap 3->0; count is 3 bits, 0..4.
- Transmitter FSM states: IDLE, START, DATA, STOP. A 16-bit bit-timer counts 0..DIV-1; a 3-bit bit index counts 0..7.
  - IDLE -> START when count>0 at the edge: pop the FIFO head into the shift register and drive tx<=0.
    - A byte written in the same cycle is not visible to this test; it starts one cycle later.
  - START -> DATA after DIV cycles: tx<=shift[0].
  - DATA: every DIV cycles, shift right and increment the index. After bit 7 has been held DIV cycles, go to STOP with tx<=1.
  - STOP, after DIV cycles:
    - if count>0: go to START, pop, tx<=0 (no idle gap between frames);
    - else: go to IDLE and set int_req.
- Status flags
  - busy = (state!=IDLE) or (count!=0).
  - full = (count==4).
- Interrupt
  - int_req is held until a cycle with ack_int=1. That cycle clears int_req and ovf.
  - If a set event and ack_int coincide, the set wins: int_req=1.
  - If an ovf set and ack_int coincide, the set wins: ovf=1.
- Reset (synchronous)
  - Outputs: tx=1, int_req=0, ovf=0, count=0, pointers=0, state=IDLE, timer=0, index=0, status=8'h00.
  - Reset mid-frame aborts the frame: tx returns high at that edge and buffered bytes are discarded.

## Timing
- Write-to-line latency from IDLE with an empty FIFO:
  - wr is sampled at edge k;
  - the FSM enters START at edge k+1, so tx falls after edge k+1.
- Frame length: exactly 10*DIV cycles, from the tx falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins at the same edge that ends the previous stop bit.
- int_req rises at the edge that ends the last stop bit, i.e. 10*DIV cycles after the final START entry.
- status and full reflect the registered state: a write at edge k is visible in count after edge k.
- There is no ready/handshake output. The CPU polls status[1] (full) before writing; writes while full are lost and flagged.

## Test plan
- Single byte, DIV=4, wr with din=8'hA5 at edge 1:
  - tx low during cycles 2-5;
  - data bits 1,0,1,0,0,1,0,1 for 4 cycles each;
  - high stop bit during cycles 38-41;
  - int_req=1 after edge 42; status=8'h04 afterwards.
- Four writes on consecutive edges (8'h01, 8'h02, 8'h03, 8'h04), DIV=4:
  - 4 contiguous frames with no idle cycles, 160 cycles total;
  - int_req asserted only after the 4th stop bit, never between frames.
- Six writes on consecutive edges 1-6 (8'h11..8'h16):
  - count goes 1,1,2,3,4;
  - the 6th write is dropped and ovf=1 after edge 6;
  - exactly 5 frames (8'h11..8'h15) appear on tx.
- ack_int asserted on the same edge int_req would be set: int_req=1 afterwards. A second ack_int one cycle later clears both int_req and ovf.
- reset asserted mid-DATA of a frame with 2 bytes queued: after the reset edge, tx=1, status=8'h00, int_req=0, and no further frames appear.
- DIV=2 boundary: a single byte 8'hFF frame lasts exactly 20 cycles, with the start bit low for exactly 2 cycles.

Source files
------------

// File: rtl/port_serial_tx_if.sv
// CPU-side port bundle for the serial transmitter: output-port write, interrupt
// acknowledge, serial line, status byte and interrupt request.
interface port_serial_tx_if;
   logic       wr;
   logic [7:0] din;
   logic       ack_int;
   logic       tx;
   logic [7:0] status;
   logic       int_req;

   modport master (
      output wr, din, ack_int,
      input  tx, status, int_req
   );

   modport slave (
      input  wr, din, ack_int,
      output tx, status, int_req
   );
endinterface

// File: rtl/port_serial_tx.sv
// Serial transmitter for the CPU output port: 4-entry byte FIFO feeding an
// asynchronous framer (start bit, 8 data bits LSB first, stop bit). A level
// interrupt is raised when the last queued frame has finished its stop bit.
module port_serial_tx #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   port_serial_tx_if.slave  bus
);

   localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
   localparam logic [2:0]  DEPTH_C  = 3'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  idx_q,   idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q,    tx_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [2:0]  count_q,  count_d;
   logic        ovf_q,    ovf_d;
   logic        int_req_q, int_req_d;
   logic [7:0]  mem_q [DEPTH];
   logic [7:0]  mem_d [DEPTH];

   logic        pop;
   logic        push;
   logic        drop;
   logic        irq_set;
   logic        bit_done;
   logic        full;
   logic        busy;

   // Framer next-state, FIFO bookkeeping and sticky flag updates
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
      irq_set  = 1'b0;
      bit_done = (timer_q == DIV_LAST);

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (count_q != 3'd0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               timer_d = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               timer_d = '0;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               timer_d = '0;
               if (count_q != 3'd0) begin
                  // chain straight into the next start bit, no idle gap
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  irq_set = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // a write while full is still taken if the head leaves this same cycle
      push = bus.wr && ((count_q != DEPTH_C) || pop);
      drop = bus.wr && (count_q == DEPTH_C) && !pop;

      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = bus.din;
      wr_ptr_d = wr_ptr_q + 2'(push);
      rd_ptr_d = rd_ptr_q + 2'(pop);
      count_d  = count_q + 3'(push) - 3'(pop);

      // set events take priority over the acknowledge
      if (drop)             ovf_d = 1'b1;
      else if (bus.ack_int) ovf_d = 1'b0;
      else                  ovf_d = ovf_q;

      if (irq_set)          int_req_d = 1'b1;
      else if (bus.ack_int) int_req_d = 1'b0;
      else                  int_req_d = int_req_q;
   end

   // Control and status registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         int_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         int_req_q <= int_req_d;
      end
   end

   // FIFO storage; contents are meaningless once the pointers are reset
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
   end

   assign full = (count_q == DEPTH_C);
   assign busy = (state_q != S_IDLE) || (count_q != 3'd0);

   assign bus.tx      = tx_q;
   assign bus.int_req = int_req_q;
   assign bus.status  = {1'b0, count_q, ovf_q, int_req_q, full, busy};

endmodule

// File: tb/tb_port_serial_tx.sv
// Directed bench for port_serial_tx: two instances (DIV=4 and DIV=2) driven
// from per-edge stimulus tables, with per-edge expected tx/int_req waveforms.
module tb_port_serial_tx;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   sel   = 0;

   logic       exp_tx  [0:299];
   logic       exp_irq [0:299];
   logic       wr_s    [0:299];
   logic [7:0] din_s   [0:299];
   logic       ack_s   [0:299];

   port_serial_tx_if b4 ();
   port_serial_tx_if b2 ();

   port_serial_tx #(.DIV(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
   port_serial_tx #(.DIV(2)) u2 (.clk(clk), .reset(reset), .bus(b2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic get_tx();
      return (sel == 0) ? b4.tx : b2.tx;
   endfunction

   function automatic logic get_irq();
      return (sel == 0) ? b4.int_req : b2.int_req;
   endfunction

   function automatic logic [7:0] get_status();
      return (sel == 0) ? b4.status : b2.status;
   endfunction

   task automatic clear_plan();
      for (int i = 0; i < 300; i++) begin
         exp_tx[i]  = 1'b1;
         exp_irq[i] = 1'b0;
         wr_s[i]    = 1'b0;
         din_s[i]   = 8'h00;
         ack_s[i]   = 1'b0;
      end
   endtask

   // Frame starting with the start bit after edge s: start, 8 data LSB first, stop
   task automatic add_frame(input int s, input int div, input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int c = 0; c < 10 * div; c++) exp_tx[s + c] = f[c / div];
   endtask

   task automatic irq_on(input int first, input int last);
      for (int i = first; i <= last; i++) exp_irq[i] = 1'b1;
   endtask

   task automatic drive_idle();
      b4.wr = 1'b0; b4.din = 8'h00; b4.ack_int = 1'b0;
      b2.wr = 1'b0; b2.din = 8'h00; b2.ack_int = 1'b0;
   endtask

   task automatic drive(input int e);
      drive_idle();
      if (sel == 0) begin
         b4.wr = wr_s[e]; b4.din = din_s[e]; b4.ack_int = ack_s[e];
      end else begin
         b2.wr = wr_s[e]; b2.din = din_s[e]; b2.ack_int = ack_s[e];
      end
   endtask

   // Apply stimulus before each edge e, then check tx/int_req after it
   task automatic run(input int from, input int to);
      for (int e = from; e <= to; e++) begin
         drive(e);
         tick();
         chk($sformatf("tx@%0d", e), {7'd0, get_tx()}, {7'd0, exp_tx[e]});
         chk($sformatf("irq@%0d", e), {7'd0, get_irq()}, {7'd0, exp_irq[e]});
      end
      drive_idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      chk("rst_tx4", {7'd0, b4.tx}, 8'h01);
      chk("rst_st4", b4.status, 8'h00);
      chk("rst_irq4", {7'd0, b4.int_req}, 8'h00);
      chk("rst_tx2", {7'd0, b2.tx}, 8'h01);
      chk("rst_st2", b2.status, 8'h00);
      reset = 1'b0;
   endtask

   initial begin
      drive_idle();
      do_reset();

      // single byte A5, DIV=4
      sel = 0;
      clear_plan();
      wr_s[1] = 1'b1; din_s[1] = 8'hA5;
      add_frame(2, 4, 8'hA5);
      irq_on(42, 50);
      run(1, 1);
      chk("t1_st_e1", get_status(), 8'h11);
      run(2, 2);
      chk("t1_st_e2", get_status(), 8'h01);
      run(3, 50);
      chk("t1_st_end", get_status(), 8'h04);
      clear_plan();
      ack_s[51] = 1'b1;
      run(51, 52);
      chk("t1_st_ack", get_status(), 8'h00);

      // four back-to-back frames; ack coincides with the set edge
      clear_plan();
      for (int i = 1; i <= 4; i++) begin
         wr_s[i] = 1'b1; din_s[i] = 8'(i);
      end
      for (int k = 0; k < 4; k++) add_frame(2 + 40 * k, 4, 8'(k + 1));
      ack_s[162] = 1'b1;
      irq_on(162, 162);
      run(1, 162);
      chk("t2_st_end", get_status(), 8'h04);
      clear_plan();
      ack_s[163] = 1'b1;
      run(163, 165);
      chk("t2_st_ack", get_status(), 8'h00);

      // six writes into a 4-deep FIFO: sixth is dropped
      clear_plan();
      for (int i = 1; i <= 6; i++) begin
         wr_s[i] = 1'b1; din_s[i] = 8'h10 + 8'(i);
      end
      for (int k = 0; k < 5; k++) add_frame(2 + 40 * k, 4, 8'h11 + 8'(k));
      irq_on(202, 210);
      run(1, 1); chk("t3_st_e1", get_status(), 8'h11);
      run(2, 2); chk("t3_st_e2", get_status(), 8'h11);
      run(3, 3); chk("t3_st_e3", get_status(), 8'h21);
      run(4, 4); chk("t3_st_e4", get_status(), 8'h31);
      run(5, 5); chk("t3_st_e5", get_status(), 8'h43);
      run(6, 6); chk("t3_st_e6", get_status(), 8'h4B);
      run(7, 210);
      chk("t3_st_end", get_status(), 8'h0C);
      clear_plan();
      ack_s[211] = 1'b1;
      run(211, 212);
      chk("t3_st_ack", get_status(), 8'h00);

      // reset in the middle of DATA with two bytes still queued
      clear_plan();
      for (int i = 1; i <= 3; i++) begin
         wr_s[i] = 1'b1; din_s[i] = 8'h20 + 8'(i);
      end
      add_frame(2, 4, 8'h21);
      run(1, 20);
      chk("t4_st_pre", get_status(), 8'h21);
      reset = 1'b1;
      tick();
      chk("t4_tx_rst", {7'd0, get_tx()}, 8'h01);
      chk("t4_st_rst", get_status(), 8'h00);
      chk("t4_irq_rst", {7'd0, get_irq()}, 8'h00);
      reset = 1'b0;
      clear_plan();
      run(1, 80);
      chk("t4_st_after", get_status(), 8'h00);

      // DIV=2 boundary: FF frame, 2-cycle start bit, 20 cycles total
      sel = 1;
      clear_plan();
      wr_s[1] = 1'b1; din_s[1] = 8'hFF;
      add_frame(2, 2, 8'hFF);
      irq_on(22, 25);
      run(1, 25);
      chk("t5_st_end", get_status(), 8'h04);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
